uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between two byte sources: source 0 is the SD card data path and source 1 is the host status/debug path.
- Accepts one byte at a time from the winning source over a valid/ready handshake.
- Issues a one-cycle start pulse to the UART transmitter, then tracks the transmitter's sending flag until the byte is done.
- Sits between the SD datapath and uart_controller's tx_data/uart_tx_en inputs, and adds round-robin fairness, a start timeout and a byte counter.

Parameters:
- START_TIMEOUT, 16: number of cycles to wait in WAIT_BUSY for uart_tx_sending to rise before flagging an error. Legal range is 2..255.
- CNT_W, 16: width of the completed-byte counter.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- src0_valid  input  1  SD source has a byte to send.
- src0_data  input  8  SD source byte.
- src0_ready  output  1  combinational accept for source 0.
- src1_valid  input  1  host source has a byte to send.
- src1_data  input  8  host source byte.
- src1_ready  output  1  combinational accept for source 1.
- prio_mode  input  1  0 = round-robin; 1 = source 0 always wins a tie.
- uart_tx_sending  input  1  transmitter busy flag.
- uart_tx_en  output  1  one-cycle start pulse to the transmitter.
- tx_data  output  8  latched byte presented to the transmitter.
- grant  output  1  index of the source owning the current byte.
- busy  output  1  high whenever state is not IDLE.
- timeout_err  output  1  sticky error flag, cleared by err_clr.
- err_clr  input  1  clears timeout_err.
- tx_count  output  CNT_W  completed bytes; wraps at the counter width.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state = IDLE; uart_tx_en, tx_data, grant, timeout_err and tx_count = 0; last_grant = 1.
  - With last_grant = 1, the first tie goes to source 0.
  - Reset mid-byte aborts immediately. The transmitter is not notified, and no count increment happens.
- Transfer rule: a byte is taken at a clock edge where srcK_valid && srcK_ready.
  - srcK_ready = (state == IDLE) && !uart_tx_sending && (sel == K).
  - A source must hold valid and data stable until accepted.
- Arbitration in IDLE:
  - Only one valid: select that source.
  - Both valid, prio_mode = 1: select source 0.
  - Both valid, prio_mode = 0: select the source that is not last_grant.
  - When no source is valid, both ready outputs are 0.
- State machine:
  - IDLE: on a transfer, latch the byte into tx_data, set grant = sel and last_grant = sel, then go to START. If uart_tx_sending is high (transmitter used elsewhere), no grant is issued.
  - START: uart_tx_en = 1 for exactly this cycle, tx_data stable. Clear the timeout counter and go to WAIT_BUSY unconditionally.
  - WAIT_BUSY:
    - If uart_tx_sending = 1, go to SENDING.
    - Otherwise increment the timeout counter. When the counter reaches START_TIMEOUT-1, set timeout_err = 1 and go to IDLE with no count increment.
  - SENDING: when uart_tx_sending = 0, increment tx_count (wrapping) and go to IDLE.
- Latency: transfer at edge N; uart_tx_en is high in cycle N+1. The earliest next accept is in the cycle after SENDING exits.
- tx_data and grant hold their values until the next transfer.
- uart_tx_en is 0 in every state other than START.
- timeout_err:
  - Set has priority over clear when both happen in the same cycle.
  - err_clr does not affect the state machine.
- prio_mode may change at any time; it only affects IDLE decisions.
- A source deasserting valid before it is accepted simply loses the arbitration; this is not an error.

Test Plan:
- Single source: src0_valid = 1 with 0xA5, transmitter model raises sending 2 cycles after the start pulse for 10 cycles → src0_ready high 1 cycle, uart_tx_en pulse 1 cycle later, tx_data = 0xA5, grant = 0, tx_count = 1 after sending falls.
- Round-robin: both sources continuously valid (src0 sends 0x11, 0x12…; src1 sends 0x21, 0x22…), prio_mode = 0, 4 bytes → grant sequence 0,1,0,1 and tx_data sequence 0x11, 0x21, 0x12, 0x22.
- Fixed priority: same stimulus with prio_mode = 1 → 4 grants all to source 0; src1_ready never high.
- Timeout: START_TIMEOUT = 16, sending never rises → timeout_err set exactly 16 cycles after the start pulse, state returns to IDLE, tx_count unchanged. Asserting err_clr then clears it.
- Busy-elsewhere: uart_tx_sending held high while in IDLE with src1_valid = 1 → src1_ready stays 0 until sending falls, then accepts in that same cycle.
- Reset mid-operation: rst_n low during SENDING → next cycle all outputs at reset values, tx_count = 0. The first tie after release goes to source 0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Handshake and transmitter-side signal bundle for uart_tx_arbiter.
// The slave modport is the arbiter's view; the master modport is the view
// of whatever drives the byte sources and models the UART transmitter.
interface uart_tx_arbiter_if #(
    parameter int unsigned CNT_W = 16
);
    logic             src0_valid;
    logic [7:0]       src0_data;
    logic             src0_ready;
    logic             src1_valid;
    logic [7:0]       src1_data;
    logic             src1_ready;
    logic             prio_mode;
    logic             uart_tx_sending;
    logic             uart_tx_en;
    logic [7:0]       tx_data;
    logic             grant;
    logic             busy;
    logic             timeout_err;
    logic             err_clr;
    logic [CNT_W-1:0] tx_count;

    modport slave (
        input  src0_valid, src0_data, src1_valid, src1_data,
        input  prio_mode, uart_tx_sending, err_clr,
        output src0_ready, src1_ready, uart_tx_en, tx_data,
        output grant, busy, timeout_err, tx_count
    );

    modport master (
        output src0_valid, src0_data, src1_valid, src1_data,
        output prio_mode, uart_tx_sending, err_clr,
        input  src0_ready, src1_ready, uart_tx_en, tx_data,
        input  grant, busy, timeout_err, tx_count
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-source arbiter in front of a single UART transmitter.
// Source 0 is the SD data path, source 1 the host status/debug path.
// One byte is taken per handshake, a one-cycle start pulse is issued, and
// the transmitter's sending flag is tracked until the byte completes.
// A start timeout raises a sticky error; completed bytes are counted.
module uart_tx_arbiter #(
    parameter int unsigned START_TIMEOUT = 16,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        SENDING   = 2'd3
    } state_t;

    // Timeout fires on the WAIT_BUSY cycle whose incremented count hits this
    // value, so the error appears START_TIMEOUT cycles after the start pulse.
    localparam logic [7:0] TMO_LAST = 8'(START_TIMEOUT - 1);

    state_t           state_r;
    state_t           state_s;
    logic [7:0]       tx_data_r;
    logic [7:0]       tx_data_s;
    logic             grant_r;
    logic             grant_s;
    logic             last_grant_r;
    logic             last_grant_s;
    logic             tx_en_r;
    logic             tx_en_s;
    logic             busy_r;
    logic             busy_s;
    logic             err_r;
    logic             err_s;
    logic             err_set_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;
    logic [7:0]       tmo_r;
    logic [7:0]       tmo_s;
    logic [7:0]       tmo_inc_s;
    logic             sel_s;
    logic             take_s;
    logic             src0_ready_s;
    logic             src1_ready_s;

    // Winner among currently valid sources; ties follow prio_mode/last_grant.
    function automatic logic pick_source(
        input logic v0,
        input logic v1,
        input logic prio,
        input logic last
    );
        logic winner;
        if (v0 && !v1) begin
            winner = 1'b0;
        end else if (!v0 && v1) begin
            winner = 1'b1;
        end else if (v0 && v1) begin
            if (prio) begin
                winner = 1'b0;
            end else begin
                winner = ~last;
            end
        end else begin
            winner = 1'b0;
        end
        return winner;
    endfunction

    // Source selection and ready generation; ready only for a valid winner.
    always_comb begin
        sel_s        = pick_source(bus.src0_valid, bus.src1_valid,
                                   bus.prio_mode, last_grant_r);
        src0_ready_s = 1'b0;
        src1_ready_s = 1'b0;
        if ((state_r == IDLE) && !bus.uart_tx_sending) begin
            src0_ready_s = bus.src0_valid && (sel_s == 1'b0);
            src1_ready_s = bus.src1_valid && (sel_s == 1'b1);
        end else begin
            src0_ready_s = 1'b0;
            src1_ready_s = 1'b0;
        end
        take_s = src0_ready_s || src1_ready_s;
    end

    assign bus.src0_ready  = src0_ready_s;
    assign bus.src1_ready  = src1_ready_s;
    assign bus.uart_tx_en  = tx_en_r;
    assign bus.tx_data     = tx_data_r;
    assign bus.grant       = grant_r;
    assign bus.busy        = busy_r;
    assign bus.timeout_err = err_r;
    assign bus.tx_count    = count_r;

    // Next-state and next-register computation for the transfer FSM.
    always_comb begin
        state_s      = state_r;
        tx_data_s    = tx_data_r;
        grant_s      = grant_r;
        last_grant_s = last_grant_r;
        tx_en_s      = 1'b0;
        tmo_s        = tmo_r;
        tmo_inc_s    = tmo_r + 8'd1;
        count_s      = count_r;
        err_set_s    = 1'b0;

        case (state_r)
            IDLE: begin
                if (take_s) begin
                    tx_data_s    = sel_s ? bus.src1_data : bus.src0_data;
                    grant_s      = sel_s;
                    last_grant_s = sel_s;
                    tx_en_s      = 1'b1;
                    state_s      = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                tmo_s   = 8'd0;
                state_s = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.uart_tx_sending) begin
                    state_s = SENDING;
                end else if (tmo_inc_s == TMO_LAST) begin
                    tmo_s     = tmo_inc_s;
                    err_set_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    tmo_s   = tmo_inc_s;
                    state_s = WAIT_BUSY;
                end
            end
            SENDING: begin
                if (!bus.uart_tx_sending) begin
                    count_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_s = IDLE;
                end else begin
                    state_s = SENDING;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s != IDLE);

        // A timeout in the same cycle as err_clr leaves the flag set.
        if (err_set_s) begin
            err_s = 1'b1;
        end else if (bus.err_clr) begin
            err_s = 1'b0;
        end else begin
            err_s = err_r;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            tx_data_r    <= 8'd0;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            tx_en_r      <= 1'b0;
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
            count_r      <= {CNT_W{1'b0}};
            tmo_r        <= 8'd0;
        end else begin
            state_r      <= state_s;
            tx_data_r    <= tx_data_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
            tx_en_r      <= tx_en_s;
            busy_r       <= busy_s;
            err_r        <= err_s;
            count_r      <= count_s;
            tmo_r        <= tmo_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// transfers compared against a transaction-level model of the arbiter rules.
module tb_uart_tx_arbiter;

    localparam int TMO = 16;
    localparam int CW  = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.CNT_W(CW)) bus_if ();

    uart_tx_arbiter #(.START_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: who was served last and how many bytes finished.
    bit          m_last;
    int unsigned m_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Arbitration rule: a lone requester wins; on a tie priority mode favours
    // source 0, round-robin favours whoever was not served last time.
    function automatic int ref_pick(bit v0, bit v1, bit prio, bit last);
        if (v0 && v1) return prio ? 0 : (last == 1'b1 ? 0 : 1);
        if (v1) return 1;
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete byte: optional busy-elsewhere phase, accept, start pulse,
    // transmitter raises sending dly cycles after the pulse for len cycles.
    task automatic transfer(input bit v0, input bit v1, input logic [7:0] d0,
                            input logic [7:0] d1, input bit prio, input int pre,
                            input int dly, input int len, output int won);
        int         exp_g;
        logic [7:0] exp_d;
        bus_if.prio_mode  = prio;
        bus_if.src0_valid = v0;
        bus_if.src1_valid = v1;
        bus_if.src0_data  = d0;
        bus_if.src1_data  = d1;
        if (pre > 0) begin
            bus_if.uart_tx_sending = 1'b1;
            for (int i = 0; i < pre; i++) begin
                #1;
                chk("blocked_rdy0", bus_if.src0_ready, 1'b0);
                chk("blocked_rdy1", bus_if.src1_ready, 1'b0);
                step();
            end
            bus_if.uart_tx_sending = 1'b0;
        end
        #1;
        exp_g = ref_pick(v0, v1, prio, m_last);
        exp_d = (exp_g == 1) ? d1 : d0;
        chk("rdy0", bus_if.src0_ready, (v0 && exp_g == 0));
        chk("rdy1", bus_if.src1_ready, (v1 && exp_g == 1));
        step();
        bus_if.src0_valid = 1'b0;
        bus_if.src1_valid = 1'b0;
        bus_if.src0_data  = ~d0;
        bus_if.src1_data  = ~d1;
        m_last = exp_g[0];
        won    = exp_g;
        chk("start_pulse", bus_if.uart_tx_en, 1'b1);
        chk("tx_data", bus_if.tx_data, exp_d);
        chk("grant", bus_if.grant, exp_g);
        chk("busy_start", bus_if.busy, 1'b1);
        for (int i = 0; i < dly; i++) begin
            step();
            if (i == 0) chk("pulse_one_cycle", bus_if.uart_tx_en, 1'b0);
        end
        bus_if.uart_tx_sending = 1'b1;
        for (int i = 0; i < len; i++) step();
        chk("count_hold", bus_if.tx_count, m_count);
        chk("busy_sending", bus_if.busy, 1'b1);
        bus_if.uart_tx_sending = 1'b0;
        step();
        m_count = (m_count + 1) % (1 << CW);
        chk("tx_count", bus_if.tx_count, m_count);
        chk("busy_done", bus_if.busy, 1'b0);
        chk("tx_data_hold", bus_if.tx_data, exp_d);
        chk("grant_hold", bus_if.grant, exp_g);
        chk("en_idle", bus_if.uart_tx_en, 1'b0);
    endtask

    // Start a byte that the transmitter never picks up.
    task automatic timeout_run(input bit clr_hold);
        bus_if.src0_valid = 1'b1;
        bus_if.src0_data  = 8'h5C;
        bus_if.prio_mode  = 1'b0;
        bus_if.err_clr    = clr_hold;
        #1;
        chk("tmo_rdy0", bus_if.src0_ready, 1'b1);
        step();
        bus_if.src0_valid = 1'b0;
        m_last = 1'b0;
        chk("tmo_pulse", bus_if.uart_tx_en, 1'b1);
        for (int k = 1; k < TMO; k++) step();
        chk("tmo_not_yet", bus_if.timeout_err, 1'b0);
        chk("tmo_busy_wait", bus_if.busy, 1'b1);
        step();
        chk("tmo_err_set", bus_if.timeout_err, 1'b1);
        chk("tmo_idle", bus_if.busy, 1'b0);
        chk("tmo_count", bus_if.tx_count, m_count);
        if (clr_hold) begin
            step();
            chk("tmo_clr_after_set", bus_if.timeout_err, 1'b0);
            bus_if.err_clr = 1'b0;
        end else begin
            step();
            chk("tmo_sticky", bus_if.timeout_err, 1'b1);
            bus_if.err_clr = 1'b1;
            step();
            bus_if.err_clr = 1'b0;
            chk("tmo_cleared", bus_if.timeout_err, 1'b0);
        end
    endtask

    initial begin
        int won;
        int n0;
        int n1;
        int exp_rr [4];
        bit v0;
        bit v1;

        bus_if.src0_valid      = 1'b0;
        bus_if.src1_valid      = 1'b0;
        bus_if.src0_data       = 8'h00;
        bus_if.src1_data       = 8'h00;
        bus_if.prio_mode       = 1'b0;
        bus_if.uart_tx_sending = 1'b0;
        bus_if.err_clr         = 1'b0;
        rst_n                  = 1'b0;
        m_last                 = 1'b1;
        m_count                = 0;

        repeat (3) step();
        chk("rst_en", bus_if.uart_tx_en, 1'b0);
        chk("rst_data", bus_if.tx_data, 8'h00);
        chk("rst_grant", bus_if.grant, 1'b0);
        chk("rst_busy", bus_if.busy, 1'b0);
        chk("rst_err", bus_if.timeout_err, 1'b0);
        chk("rst_count", bus_if.tx_count, 16'd0);
        chk("rst_rdy0", bus_if.src0_ready, 1'b0);
        rst_n = 1'b1;
        step();

        // Round-robin with both sources always requesting.
        exp_rr[0] = 0; exp_rr[1] = 1; exp_rr[2] = 0; exp_rr[3] = 1;
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 4; i++) begin
            transfer(1'b1, 1'b1, 8'(8'h11 + n0), 8'(8'h21 + n1), 1'b0, 0, 2, 3, won);
            chk("rr_sequence", won, exp_rr[i]);
            if (won == 0) n0++; else n1++;
        end

        // Fixed priority: source 0 takes every tie.
        n0 = 0;
        for (int i = 0; i < 4; i++) begin
            transfer(1'b1, 1'b1, 8'(8'h11 + n0), 8'h21, 1'b1, 0, 2, 3, won);
            chk("prio_sequence", won, 0);
            n0++;
        end

        transfer(1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 0, 2, 10, won);
        transfer(1'b0, 1'b1, 8'h00, 8'h3C, 1'b0, 3, 1, 2, won);

        timeout_run(1'b0);
        timeout_run(1'b1);

        for (int i = 0; i < 30; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            transfer(v0, v1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 2)), int'($urandom_range(1, 8)),
                     int'($urandom_range(1, 6)), won);
        end

        // Reset while the byte is in flight.
        bus_if.src0_valid = 1'b1;
        bus_if.src1_valid = 1'b1;
        bus_if.src0_data  = 8'h77;
        bus_if.src1_data  = 8'h88;
        bus_if.prio_mode  = 1'b0;
        step();
        bus_if.src0_valid = 1'b0;
        bus_if.src1_valid = 1'b0;
        step();
        bus_if.uart_tx_sending = 1'b1;
        step();
        step();
        chk("mid_busy", bus_if.busy, 1'b1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_en", bus_if.uart_tx_en, 1'b0);
        chk("mid_rst_data", bus_if.tx_data, 8'h00);
        chk("mid_rst_grant", bus_if.grant, 1'b0);
        chk("mid_rst_busy", bus_if.busy, 1'b0);
        chk("mid_rst_err", bus_if.timeout_err, 1'b0);
        chk("mid_rst_count", bus_if.tx_count, 16'd0);
        m_last  = 1'b1;
        m_count = 0;
        rst_n   = 1'b1;
        bus_if.uart_tx_sending = 1'b0;
        step();
        transfer(1'b1, 1'b1, 8'h0A, 8'h0B, 1'b0, 0, 2, 2, won);
        chk("post_rst_tie", won, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
